// File: rtl/binary_4bit_sub.sv
// rtl/binary_4bit_sub.sv - registered ripple-carry subtractor computing a + ~b + 1
// Optional two's-complement overflow output enabled by macro BINARY_4BIT_SUB_OVF_EN.
module binary_4bit_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid
`ifdef BINARY_4BIT_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] nb;
    logic [WIDTH-1:0] diff;
    logic             carry_out;
    logic             carry;

    assign nb = ~b;

    // Full-adder chain, LSB first; carry-in of 1 completes the two's complement of b.
    always_comb begin
        diff  = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = a[i] ^ nb[i] ^ carry;
            carry   = (a[i] & nb[i]) | (carry & (a[i] ^ nb[i]));
        end
        carry_out = carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s    <= diff;
                cout <= carry_out;
            end
        end
    end

`ifdef BINARY_4BIT_SUB_OVF_EN
    logic ovf_next;

    // Overflow only when operand signs differ and the result sign departs from a.
    assign ovf_next = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_binary_4bit_sub.sv
// tb/tb_binary_4bit_sub.sv - randomized self-checking bench for binary_4bit_sub
module tb_binary_4bit_sub;

    localparam int W    = 4;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         cout;
    logic         out_valid;
`ifdef BINARY_4BIT_SUB_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int m_s   = 0;
    int m_c   = 0;
    int m_v   = 0;
    int m_ovf = 0;

    binary_4bit_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .s         (s),
        .cout      (cout),
        .out_valid (out_valid)
`ifdef BINARY_4BIT_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".s"}, 32'(s), 32'(m_s));
        check({tag, ".cout"}, 32'(cout), 32'(m_c));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_v));
`ifdef BINARY_4BIT_SUB_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
`endif
    endtask

    function automatic int to_signed(input int x);
        return (x >= HALF) ? x - MOD : x;
    endfunction

    // Model: plain integer arithmetic on the operands, held when in_valid is low.
    task automatic step(input string tag, input logic v, input int ai, input int bi);
        int sd;
        @(negedge clk);
        in_valid = v;
        a = ai[W-1:0];
        b = bi[W-1:0];
        @(posedge clk);
        if (v) begin
            m_s   = (ai - bi + MOD) % MOD;
            m_c   = (ai >= bi) ? 1 : 0;
            sd    = to_signed(ai) - to_signed(bi);
            m_ovf = (sd >= HALF || sd < -HALF) ? 1 : 0;
        end
        m_v = v ? 1 : 0;
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        m_s = 0; m_c = 0; m_v = 0; m_ovf = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 4'd5;
        b = 4'd2;
        model_reset();
        #2;
        check_all("reset_t0");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;

        step("dir_8", 1'b1, 8, 8);
        step("dir_4", 1'b1, 4, 4);
        step("dir_2", 1'b1, 2, 2);
        step("dir_1", 1'b1, 1, 1);
        step("borrow", 1'b1, 3, 5);
        check("borrow_s_const", 32'(s), 32'd14);
        step("hold_load", 1'b1, 15, 1);
        step("hold_idle", 1'b0, 0, 15);
        check("hold_s_const", 32'(s), 32'd14);
        step("zero_zero", 1'b1, 0, 0);
        step("max_zero", 1'b1, 15, 0);
        step("wrap", 1'b1, 2, 9);
        step("ovf_pos", 1'b1, 7, 8);
        step("ovf_neg", 1'b1, 8, 1);

        step("pre_rst", 1'b1, 9, 3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 6, 11);

        for (int i = 0; i < 200; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, MOD - 1)),
                 int'($urandom_range(0, MOD - 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
